// File: rtl/fp_cmp_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single-precision greater-than compare
// among NUM_REQ requesters; registered result tagged with the requester index.
module fp_cmp_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_greater,
  output logic [2:0]             rsp_id,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   cmp_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_q;
  logic [ID_W-1:0]       id_q;
  logic [31:0]           a_q, b_q;
  logic [31:0]           a_arr [NUM_REQ];
  logic [31:0]           b_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       cand;
  logic                  grant_any;

  // IEEE-754 a > b: unordered (NaN) is never greater, and +0 equals -0.
  function automatic logic fp_greater(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    if (a_nan || b_nan)                return 1'b0;
    if (a[30:0] == '0 && b[30:0] == '0) return 1'b0;
    if (a[31] != b[31])                return ~a[31];
    if (!a[31])                        return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[32*i +: 32];
      b_arr[i] = req_b[32*i +: 32];
    end
  end

  // Search starts one past the last winner and wraps, giving rotating priority.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant_any) state_d = CMP;
      end
      CMP:     state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid   <= 1'b0;
      rsp_greater <= 1'b0;
      rsp_id      <= '0;
      cmp_count   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q    <= a_arr[grant_id];
            b_q    <= b_arr[grant_id];
            id_q   <= grant_id;
            last_q <= grant_id;
          end
        end
        CMP: begin
          rsp_greater <= fp_greater(a_q, b_q);
          rsp_id      <= 3'(id_q);
          rsp_valid   <= 1'b1;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmp_count <= sat_inc(cmp_count);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Randomized and directed bench for fp_cmp_arbiter against a real-valued reference model.
module tb_fp_cmp_arbiter;
  localparam int NR = 4;
  localparam int CW = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RESET_N;
  logic [NR-1:0]    req_valid;
  logic [32*NR-1:0] req_a, req_b;
  logic [NR-1:0]    req_ready;
  logic             rsp_valid, rsp_ready, rsp_greater, busy;
  logic [2:0]       rsp_id;
  logic [CW-1:0]    cmp_count;

  logic [1:0]  req_valid2, req_ready2;
  logic [63:0] req_a2, req_b2;
  logic        rsp_valid2, rsp_greater2, busy2;
  logic [2:0]  rsp_id2;
  logic [1:0]  cmp_count2;

  fp_cmp_arbiter #(.NUM_REQ(NR), .CNT_WIDTH(CW)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_greater(rsp_greater), .rsp_id(rsp_id), .busy(busy), .cmp_count(cmp_count));

  fp_cmp_arbiter #(.NUM_REQ(2), .CNT_WIDTH(2)) u_dut_sat (
    .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid2), .req_a(req_a2), .req_b(req_b2),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(1'b1),
    .rsp_greater(rsp_greater2), .rsp_id(rsp_id2), .busy(busy2), .cmp_count(cmp_count2));

  int checks = 0;
  int failures = 0;
  int model_last;
  int model_cnt;
  logic [31:0] a_op [NR];
  logic [31:0] b_op [NR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] x);
    real mag;
    int  e;
    e = int'(x[30:23]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
    else             mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic ref_greater(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 1'b0;
    return to_real(a) > to_real(b);
  endfunction

  function automatic int exp_grant(input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(model_last + k) % NR]) return (model_last + k) % NR;
    return -1;
  endfunction

  // Called at posedge+2 with the DUT idle; returns at posedge+2 with it idle again.
  task automatic issue(input logic [NR-1:0] v, input int stall, input bit scramble, output int g);
    logic          exp_gt;
    logic [NR-1:0] onehot;
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_a[32*i +: 32] = a_op[i];
      req_b[32*i +: 32] = b_op[i];
    end
    rsp_ready = (stall == 0);
    #1;
    g = exp_grant(v);
    onehot = '0;
    onehot[g] = 1'b1;
    check("grant", 32'(req_ready), 32'(onehot));
    exp_gt = ref_greater(a_op[g], b_op[g]);
    @(posedge CLK);
    model_last = g;
    #1;
    if (scramble) begin
      req_valid = (stall > 0) ? '1 : '0;
      for (int i = 0; i < NR; i++) begin
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
      end
    end
    #1;
    check("cmp_busy", 32'(busy), 32'd1);
    check("cmp_rsp_valid", 32'(rsp_valid), 32'd0);
    check("cmp_req_ready", 32'(req_ready), 32'd0);
    @(posedge CLK); #2;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_greater", 32'(rsp_greater), 32'(exp_gt));
    check("rsp_id", 32'(rsp_id), 32'(g));
    for (int c = 0; c < stall; c++) begin
      @(posedge CLK); #2;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_greater", 32'(rsp_greater), 32'(exp_gt));
      check("hold_id", 32'(rsp_id), 32'(g));
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_count", 32'(cmp_count), 32'(model_cnt));
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #2;
    if (model_cnt < (1 << CW) - 1) model_cnt++;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_count", 32'(cmp_count), 32'(model_cnt));
  endtask

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    case ($urandom_range(0, 7))
      0:       return $urandom_range(0, 1) ? 32'h8000_0000 : 32'h0000_0000;
      1:       return 32'h7FC0_0000;
      2:       return $urandom_range(0, 1) ? 32'hFF80_0000 : 32'h7F80_0000;
      3:       return other;
      4:       return {1'b0, 8'h00, 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g;
    RESET_N = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0;
    model_last = NR - 1;
    model_cnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_greater", 32'(rsp_greater), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_count", 32'(cmp_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK); #2;

    // 10.0 > 5.0 from requester 0
    a_op[0] = 32'h4120_0000; b_op[0] = 32'h40A0_0000;
    issue(4'b0001, 0, 1, g);
    check("t1_count", 32'(cmp_count), 32'd1);

    // equal and negative-vs-positive from requester 2
    a_op[2] = 32'h4120_0000; b_op[2] = 32'h4120_0000;
    issue(4'b0100, 0, 1, g);
    a_op[2] = 32'hBF80_0000; b_op[2] = 32'h40A0_0000;
    issue(4'b0100, 0, 1, g);
    a_op[2] = 32'h8000_0000; b_op[2] = 32'h0000_0000;
    issue(4'b0100, 0, 1, g);

    // stalled response, then grant follows on the next cycle
    a_op[1] = 32'h3F80_0000; b_op[1] = 32'hBF80_0000;
    issue(4'b0010, 10, 1, g);
    req_valid = 4'b0010;
    #1;
    check("post_stall_grant", 32'(req_ready), 32'h2);
    @(posedge CLK); #2;
    check("post_stall_busy", 32'(busy), 32'd1);
    req_valid = '0;
    @(posedge CLK); @(posedge CLK); #2;
    model_last = 1;
    if (model_cnt < (1 << CW) - 1) model_cnt++;
    check("post_stall_count", 32'(cmp_count), 32'(model_cnt));

    // reset during CMP after requester 2 won
    a_op[2] = 32'h4120_0000; b_op[2] = 32'h40A0_0000;
    req_valid = 4'b0100;
    for (int i = 0; i < NR; i++) begin
      req_a[32*i +: 32] = a_op[i];
      req_b[32*i +: 32] = b_op[i];
    end
    #1;
    check("t5_grant", 32'(req_ready), 32'h4);
    @(posedge CLK); #1;
    req_valid = '0;
    RESET_N = 1'b0;
    #1;
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_greater", 32'(rsp_greater), 32'd0);
    check("t5_id", 32'(rsp_id), 32'd0);
    check("t5_count", 32'(cmp_count), 32'd0);
    @(negedge CLK) RESET_N = 1'b1;
    model_last = NR - 1;
    model_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #2;
      check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = '1;
    #1;
    check("t5_first_grant", 32'(req_ready), 32'h1);

    // fairness with everyone valid
    for (int i = 0; i < NR; i++) begin
      a_op[i] = $urandom; b_op[i] = $urandom;
    end
    for (int n = 0; n < 12; n++) begin
      issue('1, 0, 0, g);
      check("rr_order", 32'(g), 32'(n % NR));
    end
    check("t3_count", 32'(cmp_count), 32'd12);

    // random masks and operands, including specials
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NR; i++) begin
        b_op[i] = rand_op($urandom);
        a_op[i] = rand_op(b_op[i]);
      end
      issue(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(0, 2), 1, g);
    end

    // saturating counter on the narrow instance
    req_a2 = {32'h4120_0000, 32'h4120_0000};
    req_b2 = {32'h40A0_0000, 32'h40A0_0000};
    req_valid2 = 2'b01;
    for (int n = 1; n <= 5; n++) begin
      repeat (3) @(posedge CLK);
      #1;
      check("sat_count", 32'(cmp_count2), 32'((n < 3) ? n : 3));
    end
    req_valid2 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
